// File: rtl/dmem_arbiter_if.sv
// Purpose: bundles the CPU load/store port, the reverb stream fetch port and the
//          single-port RAM port shared by dmem_arbiter.
// Ports:   slave  = arbiter side (takes requests and mem_rdata; drives grants, stall, read data, RAM controls)
//          master = environment side (CPU, stream engine and RAM model)
interface dmem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    // CPU load/store path
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    // Reverb sample-stream fetch path
    logic          str_req;
    logic [AW-1:0] str_addr;
    logic          str_gnt;
    logic [DW-1:0] str_rdata;
    logic          str_rvalid;
    // Synchronous single-port RAM, 1-cycle read latency
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  str_req, str_addr,
        output str_gnt, str_rdata, str_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output str_req, str_addr,
        input  str_gnt, str_rdata, str_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: arbitrates one single-port data RAM between the CPU (fixed priority) and the reverb
//          stream fetcher; the stream takes the port after STARVE_MAX consecutive denied cycles.
// Latency: CPU store issues with zero stall; CPU load costs one stall cycle; stream data and
//          cpu load data are both valid the cycle after issue.
// Backpressure: the CPU is frozen through cpu_stall; the stream sees str_gnt per cycle.
// Ports:   clk, rst_n (async active-low), bus (dmem_arbiter_if.slave).
// Option:  define DMEM_ARB_STATS_EN to add saturating counters stat_cpu_stall_cnt / stat_str_gnt_cnt.
module dmem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_arbiter_if.slave        bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]          stat_cpu_stall_cnt,
    output logic [15:0]          stat_str_gnt_cnt
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        CPU_RD = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        state_q, state_d;
    logic [3:0]    starve_cnt_q, starve_cnt_d;
    logic          str_pend_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] str_rdata_q;
    logic          cpu_issue;
    logic          str_issue;
    logic          cpu_rvalid;

    // A CPU load is in flight exactly while the FSM sits in CPU_RD.
    assign cpu_rvalid     = (state_q == CPU_RD);
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.str_rvalid = str_pend_q;
    // Read data is taken straight from the RAM in the valid cycle and held afterwards.
    assign bus.cpu_rdata  = cpu_rvalid ? bus.mem_rdata : cpu_rdata_q;
    assign bus.str_rdata  = str_pend_q ? bus.mem_rdata : str_rdata_q;

    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        cpu_issue     = 1'b0;
        str_issue     = 1'b0;
        bus.cpu_stall = bus.cpu_req;
        bus.str_gnt   = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;

        // Outputs are held quiet combinationally while reset is asserted.
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (bus.str_req && (!bus.cpu_req || starve_cnt_q == STARVE_LIM)) begin
                        str_issue = 1'b1;
                    end else if (bus.cpu_req) begin
                        cpu_issue = 1'b1;
                    end
                end
                CPU_RD: begin
                    // Load data returns now; the request still visible is the one being
                    // answered, so the port is free for the stream.
                    str_issue     = bus.str_req;
                    bus.cpu_stall = 1'b0;
                    state_d       = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (cpu_issue) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = bus.cpu_we;
                bus.cpu_stall = !bus.cpu_we;
                if (!bus.cpu_we) begin
                    state_d = CPU_RD;
                end
            end

            if (str_issue) begin
                bus.str_gnt  = 1'b1;
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.str_addr;
            end

            if (str_issue) begin
                starve_cnt_d = '0;
            end else if (bus.str_req && starve_cnt_q < STARVE_LIM) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            str_pend_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            str_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            str_pend_q   <= str_issue;
            if (cpu_rvalid) begin
                cpu_rdata_q <= bus.mem_rdata;
            end
            if (str_pend_q) begin
                str_rdata_q <= bus.mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cpu_stall_cnt <= '0;
            stat_str_gnt_cnt   <= '0;
        end else begin
            if (bus.cpu_stall && stat_cpu_stall_cnt != 16'hFFFF) begin
                stat_cpu_stall_cnt <= stat_cpu_stall_cnt + 16'd1;
            end
            if (bus.str_gnt && stat_str_gnt_cnt != 16'hFFFF) begin
                stat_str_gnt_cnt <= stat_str_gnt_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: self-checking bench for dmem_arbiter: directed scenarios followed by random traffic,
//          every cycle compared against a per-cycle reference model of the arbitration rules.
// Ports:   none (top-level bench); instantiates dmem_arbiter_if and a behavioural RAM.
module tb_dmem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_cpu_stall_cnt;
    logic [15:0] stat_str_gnt_cnt;
`endif

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_cpu_stall_cnt (stat_cpu_stall_cnt),
        .stat_str_gnt_cnt   (stat_str_gnt_cnt)
`endif
    );

    // Initial RAM contents: a fixed pattern until a word is first written.
    function automatic logic [DW-1:0] pattern(input int a);
        return {16'hCAFE, 16'(a * 7 + 3)};
    endfunction

    // Behavioural synchronous RAM with 1-cycle read latency.
    logic [DW-1:0] ram     [0:(1<<AW)-1];
    bit            written [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr]     = bus.mem_wdata;
                written[bus.mem_addr] = 1'b1;
            end else begin
                bus.mem_rdata <= written[bus.mem_addr] ? ram[bus.mem_addr] : pattern(int'(bus.mem_addr));
            end
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            m_rd_last;
    int            m_starve;
    bit            pc_v, ps_v;
    logic [DW-1:0] pc_d, ps_d, lc_d, ls_d;
    int            m_stall_cnt, m_gnt_cnt;

    // Snapshots of the last checked cycle, for directed literal checks
    logic          o_stall, o_gnt, o_mem_en, o_mem_we, o_cpu_rv, o_str_rv;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_cpu_rd, o_str_rd;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already applied; check at the falling edge, advance the model,
    // then return just after the next rising edge.
    task automatic tick();
        bit str_w, cpu_w, exp_stall;
        @(negedge clk);
        o_stall    = bus.cpu_stall;
        o_gnt      = bus.str_gnt;
        o_mem_en   = bus.mem_en;
        o_mem_we   = bus.mem_we;
        o_mem_addr = bus.mem_addr;
        o_cpu_rv   = bus.cpu_rvalid;
        o_cpu_rd   = bus.cpu_rdata;
        o_str_rv   = bus.str_rvalid;
        o_str_rd   = bus.str_rdata;
        if (!rst_n) begin
            chk("rst_cpu_rvalid", 64'(o_cpu_rv), 64'd0);
            chk("rst_str_rvalid", 64'(o_str_rv), 64'd0);
            chk("rst_cpu_rdata",  64'(o_cpu_rd), 64'd0);
            chk("rst_str_rdata",  64'(o_str_rd), 64'd0);
            chk("rst_mem_en",     64'(o_mem_en), 64'd0);
            chk("rst_mem_we",     64'(o_mem_we), 64'd0);
            chk("rst_str_gnt",    64'(o_gnt),    64'd0);
            chk("rst_cpu_stall",  64'(o_stall),  64'(bus.cpu_req));
            m_rd_last = 0; m_starve = 0; pc_v = 0; ps_v = 0;
            lc_d = '0; ls_d = '0; m_stall_cnt = 0; m_gnt_cnt = 0;
        end else begin
            chk("cpu_rvalid", 64'(o_cpu_rv), 64'(pc_v));
            chk("cpu_rdata",  64'(o_cpu_rd), 64'(pc_v ? pc_d : lc_d));
            chk("str_rvalid", 64'(o_str_rv), 64'(ps_v));
            chk("str_rdata",  64'(o_str_rd), 64'(ps_v ? ps_d : ls_d));
            if (pc_v) lc_d = pc_d;
            if (ps_v) ls_d = ps_d;
            // Who owns the port this cycle
            if (m_rd_last) begin
                cpu_w = 0;
                str_w = bus.str_req;
            end else begin
                str_w = bus.str_req && (!bus.cpu_req || m_starve == SM);
                cpu_w = bus.cpu_req && !str_w;
            end
            exp_stall = bus.cpu_req && !m_rd_last && !(cpu_w && bus.cpu_we);
            chk("cpu_stall", 64'(o_stall),  64'(exp_stall));
            chk("str_gnt",   64'(o_gnt),    64'(str_w));
            chk("mem_en",    64'(o_mem_en), 64'(str_w || cpu_w));
            chk("mem_we",    64'(o_mem_we), 64'(cpu_w && bus.cpu_we));
            if (str_w || cpu_w)
                chk("mem_addr", 64'(o_mem_addr), 64'(str_w ? bus.str_addr : bus.cpu_addr));
            if (cpu_w && bus.cpu_we)
                chk("mem_wdata", 64'(bus.mem_wdata), 64'(bus.cpu_wdata));
            pc_v = cpu_w && !bus.cpu_we;
            if (pc_v) pc_d = ref_mem[bus.cpu_addr];
            ps_v = str_w;
            if (ps_v) ps_d = ref_mem[bus.str_addr];
            if (cpu_w && bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
            m_rd_last = pc_v;
            if (str_w) m_starve = 0;
            else if (bus.str_req && m_starve < SM) m_starve++;
            if (exp_stall) m_stall_cnt++;
            if (str_w) m_gnt_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input bit req, input bit we, input int a, input logic [DW-1:0] d);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = AW'(a);
        bus.cpu_wdata = d;
    endtask

    task automatic str_set(input bit req, input int a);
        bus.str_req  = req;
        bus.str_addr = AW'(a);
    endtask

    initial begin
        bit cpu_busy;
        int k;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = pattern(i);
        rst_n = 1'b0;
        cpu_set(1, 0, 0, '0);
        str_set(1, 0);

        // Reset state, with requests present
        tick();
        tick();
        chk("reset_stall_follows_req", 64'(o_stall), 64'd1);
        rst_n = 1'b1;
        cpu_set(0, 0, 0, '0);
        str_set(0, 0);
        tick();

        // CPU store, zero-latency
        cpu_set(1, 1, 'h005, 32'hDEADBEEF);
        tick();
        chk("store_mem_en",   64'(o_mem_en),   64'd1);
        chk("store_mem_we",   64'(o_mem_we),   64'd1);
        chk("store_mem_addr", 64'(o_mem_addr), 64'h005);
        chk("store_stall",    64'(o_stall),    64'd0);
        cpu_set(1, 1, 'h010, 32'h12345678);
        tick();

        // CPU load: one stall cycle, then data
        cpu_set(1, 0, 'h010, '0);
        tick();
        chk("load_c0_stall", 64'(o_stall),  64'd1);
        chk("load_c0_we",    64'(o_mem_we), 64'd0);
        tick();
        chk("load_c1_rvalid", 64'(o_cpu_rv), 64'd1);
        chk("load_c1_rdata",  64'(o_cpu_rd), 64'h12345678);
        chk("load_c1_stall",  64'(o_stall),  64'd0);
        cpu_set(1, 0, 'h005, '0);
        tick();
        tick();
        chk("load_back_store", 64'(o_cpu_rd), 64'hDEADBEEF);
        cpu_set(0, 0, 0, '0);
        tick();
        chk("rdata_hold", 64'(o_cpu_rd), 64'hDEADBEEF);

        // Stream burst with no CPU traffic
        for (int i = 0; i < 8; i++) begin
            str_set(1, i);
            tick();
            chk("burst_gnt", 64'(o_gnt), 64'd1);
            if (i > 0) begin
                chk("burst_rvalid", 64'(o_str_rv), 64'd1);
                chk("burst_rdata",  64'(o_str_rd), 64'((i - 1 == 5) ? 32'hDEADBEEF : pattern(i - 1)));
            end
        end
        str_set(0, 0);
        tick();
        chk("burst_last_rdata", 64'(o_str_rd), 64'(pattern(7)));

        // Starvation guard: back-to-back CPU stores vs a waiting stream
        str_set(1, 'h033);
        k = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            cpu_set(1, 1, 'h060 + k, 32'h5500_0000 + 32'(k));
            tick();
            chk("starve_gnt",   64'(o_gnt),   64'(cyc == 5));
            chk("starve_stall", 64'(o_stall), 64'(cyc == 5));
            if (!o_stall) k++;
        end
        cpu_set(0, 0, 0, '0);
        str_set(0, 0);
        tick();

        // Overlap: stream issues in the CPU_RD cycle
        cpu_set(1, 1, 'h020, 32'hA1A1A1A1);
        tick();
        cpu_set(1, 1, 'h030, 32'hB2B2B2B2);
        tick();
        cpu_set(1, 0, 'h020, '0);
        str_set(1, 'h030);
        tick();
        chk("ovl_c0_gnt",   64'(o_gnt),   64'd0);
        chk("ovl_c0_stall", 64'(o_stall), 64'd1);
        tick();
        chk("ovl_c1_gnt",    64'(o_gnt),    64'd1);
        chk("ovl_c1_rvalid", 64'(o_cpu_rv), 64'd1);
        chk("ovl_c1_rdata",  64'(o_cpu_rd), 64'hA1A1A1A1);
        cpu_set(0, 0, 0, '0);
        str_set(0, 0);
        tick();
        chk("ovl_c2_str_rvalid", 64'(o_str_rv), 64'd1);
        chk("ovl_c2_str_rdata",  64'(o_str_rd), 64'hB2B2B2B2);
        chk("ovl_c2_cpu_rvalid", 64'(o_cpu_rv), 64'd0);

        // Reset while a CPU load is in flight
        cpu_set(1, 0, 'h010, '0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_cpu_rvalid", 64'(o_cpu_rv), 64'd0);
        chk("midrst_str_rvalid", 64'(o_str_rv), 64'd0);
        rst_n = 1'b1;
        cpu_set(0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postrst_cpu_rvalid", 64'(o_cpu_rv), 64'd0);
            chk("postrst_str_rvalid", 64'(o_str_rv), 64'd0);
        end

        // Random traffic; the CPU holds its request until it sees cpu_stall low
        cpu_busy = 0;
        for (int n = 0; n < 400; n++) begin
            if (!cpu_busy) begin
                cpu_set(($urandom % 3) != 0, $urandom % 2, $urandom_range(0, 31), $urandom);
                cpu_busy = bus.cpu_req;
            end
            str_set(($urandom % 2) == 1, $urandom_range(0, 31));
            tick();
            if (bus.cpu_req && !o_stall) cpu_busy = 0;
        end

`ifdef DMEM_ARB_STATS_EN
        chk("stat_cpu_stall_cnt", 64'(stat_cpu_stall_cnt), 64'(m_stall_cnt > 65535 ? 65535 : m_stall_cnt));
        chk("stat_str_gnt_cnt",   64'(stat_str_gnt_cnt),   64'(m_gnt_cnt > 65535 ? 65535 : m_gnt_cnt));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Single-port data-memory arbiter and sequencer shared by the CPU load/store path (LDR/STR/STXT) and the reverb sample-stream fetch engine. CPU has fixed priority, subject to a starvation guard for the stream. Drives a synchronous single-port RAM with 1-cycle read latency. Stalls the CPU pipeline while a CPU access is pending.

Parameters:
AW, 10, address width (words)
DW, 32, data width
STARVE_MAX, 4, consecutive denied stream cycles before the stream gets priority (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU memory request; held with addr/we/wdata until cpu_stall low
cpu_we  in  1  1 = store (STR/STXT), 0 = load (LDR)
cpu_addr  in  AW  CPU word address
cpu_wdata  in  DW  CPU store data
cpu_stall  out  1  freeze CPU pipeline
cpu_rdata  out  DW  load data, valid when cpu_rvalid
cpu_rvalid  out  1  load data valid (one cycle)
str_req  in  1  stream read request
str_addr  in  AW  stream word address
str_gnt  out  1  stream request accepted this cycle
str_rdata  out  DW  stream read data
str_rvalid  out  1  stream data valid (one cycle, cycle after str_gnt)
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data, valid cycle after read issue

Behaviour:
- Reset (rst_n low, async): state=IDLE, starve_cnt=0, str_pend=0, cpu_rdata=0, str_rdata=0, cpu_rvalid=0, str_rvalid=0. Combinational outputs in reset: mem_en=0, mem_we=0, str_gnt=0, cpu_stall=cpu_req.
- FSM states: IDLE, CPU_RD.
- Port selection (combinational, one issue per cycle):
  - In IDLE: a CPU request wins unless starve_cnt==STARVE_MAX and str_req, in which case the stream wins.
  - In CPU_RD: a CPU request is never re-issued. The port goes to the stream if str_req.
- CPU write granted: mem_en=1, mem_we=1, cpu_stall=0 same cycle (zero-latency store). State stays IDLE.
- CPU read granted: mem_en=1, mem_we=0, cpu_stall=1. IDLE->CPU_RD.
  - Next cycle: cpu_rdata<=mem_rdata, cpu_rvalid=1, cpu_stall=0, CPU_RD->IDLE.
  - Load total = 1 stall cycle.
- CPU denied (stream priority): cpu_stall=1, no state change.
- Stream grant: str_gnt=1, mem_en=1, mem_we=0, mem_addr=str_addr.
  - str_pend set; next cycle str_rdata<=mem_rdata, str_rvalid=1.
  - Back-to-back stream grants are allowed every cycle.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle str_req=1 and str_gnt=0.
  - Clears on str_gnt.
  - Holds when str_req=0.
- Simultaneous return: CPU_RD cycle with a stream issue is legal. The CPU data returns and the stream issues in the same cycle, and both rvalid paths are independent.
- Outputs cpu_rvalid/str_rvalid are registered. rdata holds its last value when not valid.
- If cpu_req drops in CPU_RD (illegal), the read still completes, cpu_rvalid pulses, and the FSM returns to IDLE.
- Reset mid-operation: pending reads are discarded and no rvalid is produced afterwards.
- No request: mem_en=0. mem_addr/mem_wdata are don't-care, driven from the CPU inputs.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined: adds outputs stat_cpu_stall_cnt (16) and stat_str_gnt_cnt (16).
  - stat_cpu_stall_cnt increments on each cycle with cpu_stall=1.
  - stat_str_gnt_cnt increments on each str_gnt.
  - Both saturate at 16'hFFFF and are cleared by reset.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical.

Test Plan:
- CPU store only: cpu_req=1, we=1, addr=0x005, wdata=0xDEADBEEF -> same cycle mem_en=1, mem_we=1, mem_addr=0x005, cpu_stall=0. Later load of 0x005 returns 0xDEADBEEF.
- CPU load: addr=0x010 holding 0x12345678 -> cycle0 cpu_stall=1, mem_we=0; cycle1 cpu_rvalid=1, cpu_rdata=0x12345678, cpu_stall=0.
- Stream burst, no CPU: str_req held 8 cycles, addr 0..7 -> str_gnt=1 every cycle, str_rvalid each following cycle with the matching data, in order.
- Starvation, STARVE_MAX=4: CPU issues back-to-back stores while str_req=1 -> stream denied 4 cycles. 5th cycle str_gnt=1, cpu_stall=1, starve_cnt->0. 6th cycle CPU store proceeds.
- Overlap: CPU load at 0x020 while stream requests 0x030 -> CPU issues in cycle0. Stream granted in cycle1 (CPU_RD) while cpu_rvalid=1. Cycle2 str_rvalid=1 with data@0x030.
- Reset mid-read: assert rst_n=0 in CPU_RD -> cpu_rvalid/str_rvalid=0, state IDLE, starve_cnt=0 immediately, with no stale rvalid after release.
